// File: rtl/softmax_vector_sequencer.sv
// softmax_vector_sequencer
//
// Purpose:
//   Drives one dual-port block RAM as the vector buffer of the softmax pipeline.
//   The block first loads an incoming score vector through RAM port A. While it
//   loads, it tracks the vector length and the signed maximum. It then replays
//   the stored vector through RAM port B to the exponent stage. The replay side
//   uses valid/ready handshaking so the downstream stage can apply backpressure.
//
// Configuration:
//   SOFTMAX_SEQ_MAX_TRACK_EN - when defined, vec_max tracks the signed maximum
//   of the loaded vector. When undefined, the comparator and register are
//   removed and vec_max is tied to 0.
//
// Ports:
//   clock, reset_n              single rising-edge clock, async active-low reset
//   in_valid/in_ready/in_data/in_last      score input stream
//   out_valid/out_ready/out_data/out_last  replay stream (out_data = RAM port B data)
//   vec_max, vec_len, overflow  vector statistics and sticky truncation flag
//   ram_enable_a, ram_write_enable_a, ram_address_a, ram_input_data_a  RAM port A (write)
//   ram_enable_b, ram_address_b, ram_output_data_b                     RAM port B (read)

module softmax_vector_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 10,
  parameter int TOTAL_WORDS = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic [DATA_WIDTH-1:0] vec_max,
  output logic [ADDR_WIDTH:0]   vec_len,
  output logic                  overflow,
  output logic                  ram_enable_a,
  output logic                  ram_write_enable_a,
  output logic [ADDR_WIDTH-1:0] ram_address_a,
  output logic [DATA_WIDTH-1:0] ram_input_data_a,
  output logic                  ram_enable_b,
  output logic [ADDR_WIDTH-1:0] ram_address_b,
  input  logic [DATA_WIDTH-1:0] ram_output_data_b
);

  localparam int LEN_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_PRIME,
    ST_DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]  vec_len_q, vec_len_d;
  logic                  overflow_q, overflow_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_last_q, out_last_d;
  logic                  accept;
  logic                  full_beat;

  always_comb begin
    state_d            = state_q;
    wr_ptr_d           = wr_ptr_q;
    rd_ptr_d           = rd_ptr_q;
    vec_len_d          = vec_len_q;
    overflow_d         = overflow_q;
    out_valid_d        = out_valid_q;
    out_last_d         = out_last_q;
    in_ready           = 1'b0;
    accept             = 1'b0;
    ram_enable_a       = 1'b0;
    ram_write_enable_a = 1'b0;
    ram_address_a      = wr_ptr_q;
    ram_input_data_a   = in_data;
    ram_enable_b       = 1'b0;
    ram_address_b      = '0;
    // True when the beat being accepted would be beat number TOTAL_WORDS.
    full_beat          = (vec_len_q == LEN_WIDTH'(TOTAL_WORDS - 1));

    case (state_q)
      ST_LOAD: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (accept) begin
          ram_enable_a       = 1'b1;
          ram_write_enable_a = 1'b1;
          wr_ptr_d           = wr_ptr_q + ADDR_WIDTH'(1);
          vec_len_d          = vec_len_q + LEN_WIDTH'(1);
          // An accepted beat clears any previous truncation flag.
          // The flag is set again only if this beat fills the RAM without in_last.
          overflow_d         = full_beat && !in_last;
          if (in_last || full_beat) begin
            state_d = ST_PRIME;
          end
        end
      end

      ST_PRIME: begin
        // Read element 0 now, so that the first beat is valid on entry to DRAIN.
        ram_enable_b  = 1'b1;
        ram_address_b = '0;
        rd_ptr_d      = ADDR_WIDTH'(1);
        out_valid_d   = 1'b1;
        out_last_d    = (vec_len_q == LEN_WIDTH'(1));
        state_d       = ST_DRAIN;
      end

      ST_DRAIN: begin
        // While stalled, port B stays disabled. The RAM output register then
        // holds out_data steady.
        if (out_valid_q && out_ready) begin
          if (out_last_q) begin
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            wr_ptr_d    = '0;
            vec_len_d   = '0;
            state_d     = ST_LOAD;
          end else begin
            ram_enable_b  = 1'b1;
            ram_address_b = rd_ptr_q;
            rd_ptr_d      = rd_ptr_q + ADDR_WIDTH'(1);
            out_last_d    = ({1'b0, rd_ptr_q} == (vec_len_q - LEN_WIDTH'(1)));
          end
        end
      end

      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_LOAD;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      vec_len_q   <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      vec_len_q   <= vec_len_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

`ifdef SOFTMAX_SEQ_MAX_TRACK_EN
  logic [DATA_WIDTH-1:0] vec_max_q, vec_max_d;

  // The first beat of a vector seeds the maximum.
  // Each later beat replaces it only if it is larger in signed terms.
  always_comb begin
    vec_max_d = vec_max_q;
    if (accept && ((vec_len_q == '0) || ($signed(in_data) > $signed(vec_max_q)))) begin
      vec_max_d = in_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vec_max_q <= '0;
    end else begin
      vec_max_q <= vec_max_d;
    end
  end

  assign vec_max = vec_max_q;
`else
  assign vec_max = '0;
`endif

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = ram_output_data_b;
  assign vec_len   = vec_len_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_softmax_vector_sequencer.sv
// tb_softmax_vector_sequencer
//
// Purpose:
//   Self-checking bench for softmax_vector_sequencer. The DUT is configured
//   with an 8-word buffer so that truncation can be exercised. The bench
//   includes a behavioural dual-port RAM with a registered port B read.
//   Expected replay data, last flags, length and maximum come from a simple
//   model of the vector held in a queue.

module tb_softmax_vector_sequencer;

  localparam int DW = 32;
  localparam int AW = 4;
  localparam int TW = 8;

  logic          clock;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic [DW-1:0] vec_max;
  logic [AW:0]   vec_len;
  logic          overflow;
  logic          ram_enable_a;
  logic          ram_write_enable_a;
  logic [AW-1:0] ram_address_a;
  logic [DW-1:0] ram_input_data_a;
  logic          ram_enable_b;
  logic [AW-1:0] ram_address_b;
  logic [DW-1:0] ram_output_data_b;

  int checks = 0;
  int errors = 0;
  int vec_q[$];
  int got_q[$];
  bit got_last_q[$];
  int first_valid;

  softmax_vector_sequencer #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .TOTAL_WORDS(TW)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_last           (in_last),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_data          (out_data),
    .out_last          (out_last),
    .vec_max           (vec_max),
    .vec_len           (vec_len),
    .overflow          (overflow),
    .ram_enable_a      (ram_enable_a),
    .ram_write_enable_a(ram_write_enable_a),
    .ram_address_a     (ram_address_a),
    .ram_input_data_a  (ram_input_data_a),
    .ram_enable_b      (ram_enable_b),
    .ram_address_b     (ram_address_b),
    .ram_output_data_b (ram_output_data_b)
  );

  // Behavioural block RAM: port A writes, port B reads with a one-cycle registered output.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (ram_enable_a && ram_write_enable_a) mem[ram_address_a] <= ram_input_data_a;
    if (ram_enable_b) ram_output_data_b <= mem[ram_address_b];
  end

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected vec_max of the vector in vec_q. It is 0 when max tracking is compiled out.
  function automatic int model_max();
    int mx;
    mx = vec_q[0];
    foreach (vec_q[i]) if (vec_q[i] > mx) mx = vec_q[i];
`ifdef SOFTMAX_SEQ_MAX_TRACK_EN
    return mx;
`else
    return 0;
`endif
  endfunction

  // Offer each element of vec_q in turn. On every accepted beat, confirm the port A write.
  // Returns just after the clock edge that accepts the final beat.
  task automatic load_vector(input bit with_last);
    int n;
    n = vec_q.size();
    for (int i = 0; i < n; i++) begin
      int budget;
      budget = 50;
      @(negedge clock);
      in_valid = 1'b1;
      in_data  = DW'(vec_q[i]);
      in_last  = with_last && (i == n - 1);
      #1;
      while (!in_ready && budget > 0) begin
        @(negedge clock);
        #1;
        budget--;
      end
      checks++;
      if (!in_ready) begin
        errors++;
        $display("[TB] FAIL load_timeout beat %0d: in_ready=%0b, required 1", i, in_ready);
      end else if (ram_enable_a !== 1'b1 || ram_write_enable_a !== 1'b1 ||
                   ram_address_a !== AW'(i) || ram_input_data_a !== DW'(vec_q[i])) begin
        errors++;
        $display("[TB] FAIL port_a_write beat %0d: en=%0b we=%0b addr=%0d data=%0d, required 1 1 %0d %0d",
                 i, ram_enable_a, ram_write_enable_a, ram_address_a, $signed(ram_input_data_a), i, vec_q[i]);
      end
      @(posedge clock);
    end
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Collect replay beats into got_q/got_last_q until out_last is seen, or until
  // max_hs beats are collected (0 = no limit).
  // mode 0: out_ready held at 1; mode 1: 1,0,0,1 pattern; mode 2: random.
  // Returns just after the edge of the final handshake.
  task automatic drain_vector(input int max_hs, input int mode);
    int       budget;
    int       cyc;
    bit       done;
    bit       stalled;
    logic [DW-1:0] held_data;
    logic     held_last;
    bit       pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    budget = 200;
    cyc = 0;
    done = 1'b0;
    stalled = 1'b0;
    first_valid = -1;
    got_q.delete();
    got_last_q.delete();
    while (!done && budget > 0) begin
      @(negedge clock);
      if (mode == 1) out_ready = pat[cyc % 4];
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else out_ready = 1'b1;
      #1;
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && !out_ready) begin
        checks++;
        if (ram_enable_b !== 1'b0) begin
          errors++;
          $display("[TB] FAIL stall_ram_enable_b: got %0b, required 0", ram_enable_b);
        end
        if (!stalled) begin
          stalled   = 1'b1;
          held_data = out_data;
          held_last = out_last;
        end else begin
          checks++;
          if (out_data !== held_data || out_last !== held_last) begin
            errors++;
            $display("[TB] FAIL stall_hold: data=%0d last=%0b, required %0d %0b",
                     $signed(out_data), out_last, $signed(held_data), held_last);
          end
        end
      end else if (out_valid && out_ready) begin
        if (stalled) begin
          checks++;
          if (out_data !== held_data) begin
            errors++;
            $display("[TB] FAIL stall_release: data=%0d, required %0d", $signed(out_data), $signed(held_data));
          end
        end
        stalled = 1'b0;
        got_q.push_back(int'(out_data));
        got_last_q.push_back(out_last);
        if (out_last || (max_hs > 0 && got_q.size() == max_hs)) done = 1'b1;
      end
      cyc++;
      budget--;
      if (done) @(posedge clock);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL drain_timeout: collected %0d beats, required completion", got_q.size());
    end
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || overflow !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: valid=%0b last=%0b ovf=%0b, required 0 0 0", out_valid, out_last, overflow);
    end
    checks++;
    if (vec_len !== '0 || vec_max !== '0) begin
      errors++;
      $display("[TB] FAIL reset_stats: len=%0d max=%0d, required 0 0", vec_len, $signed(vec_max));
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready);
    end
    checks++;
    if (ram_enable_a !== 1'b0 || ram_enable_b !== 1'b0 || ram_address_a !== '0 || ram_address_b !== '0) begin
      errors++;
      $display("[TB] FAIL reset_ram: ena=%0b enb=%0b adda=%0d addb=%0d, required 0 0 0 0",
               ram_enable_a, ram_enable_b, ram_address_a, ram_address_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    vec_q = '{5, -3, 9, 2};
    load_vector(1'b1);
    // The state is now PRIME: the read of element 0 is being issued.
    @(negedge clock);
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || ram_enable_b !== 1'b1 || ram_address_b !== '0) begin
      errors++;
      $display("[TB] FAIL basic_prime: valid=%0b in_ready=%0b enb=%0b addb=%0d, required 0 0 1 0",
               out_valid, in_ready, ram_enable_b, ram_address_b);
    end
    checks++;
    if (vec_len !== 5'(4) || vec_max !== DW'(model_max())) begin
      errors++;
      $display("[TB] FAIL basic_stats: len=%0d max=%0d, required 4 %0d", vec_len, $signed(vec_max), model_max());
    end
    drain_vector(0, 0);
    checks++;
    if (first_valid !== 0) begin
      errors++;
      $display("[TB] FAIL basic_latency: first valid at drain cycle %0d, required 0", first_valid);
    end
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL basic_count: got %0d beats, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] != vec_q[i] || got_last_q[i] != (i == 3)) begin
          errors++;
          $display("[TB] FAIL basic_beat %0d: data=%0d last=%0b, required %0d %0b",
                   i, got_q[i], got_last_q[i], vec_q[i], (i == 3));
        end
      end
    end
    checks++;
    if (in_ready !== 1'b1 || vec_len !== '0 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_return: in_ready=%0b len=%0d valid=%0b, required 1 0 0", in_ready, vec_len, out_valid);
    end
  endtask

  task automatic test_stall();
    vec_q = '{5, -3, 9, 2};
    load_vector(1'b1);
    drain_vector(0, 1);
    checks++;
    if (got_q.size() != 4) begin
      errors++;
      $display("[TB] FAIL stall_count: got %0d beats, required 4", got_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (got_q[i] != vec_q[i] || got_last_q[i] != (i == 3)) begin
          errors++;
          $display("[TB] FAIL stall_beat %0d: data=%0d last=%0b, required %0d %0b",
                   i, got_q[i], got_last_q[i], vec_q[i], (i == 3));
        end
      end
    end
  endtask

  task automatic test_single();
    vec_q = '{-7};
    load_vector(1'b1);
    @(negedge clock);
    #1;
    checks++;
    if (vec_len !== 5'(1) || vec_max !== DW'(model_max())) begin
      errors++;
      $display("[TB] FAIL single_stats: len=%0d max=%0d, required 1 %0d", vec_len, $signed(vec_max), model_max());
    end
    drain_vector(0, 0);
    checks++;
    if (got_q.size() != 1 || got_q[0] != -7 || got_last_q[0] != 1'b1) begin
      errors++;
      $display("[TB] FAIL single_beat: count=%0d first=%0d, required 1 beat of -7 with last", got_q.size(),
               (got_q.size() > 0) ? got_q[0] : 0);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL single_in_ready: got %0b, required 1", in_ready);
    end
  endtask

  task automatic test_overflow();
    vec_q = '{0, 1, 2, 3, 4, 5, 6, 7};
    load_vector(1'b0);
    // Beat 8 is now offered and must be held off until the replay finishes.
    in_valid = 1'b1;
    in_data  = DW'(8);
    in_last  = 1'b0;
    @(negedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b0 || overflow !== 1'b1 || vec_len !== 5'(8)) begin
      errors++;
      $display("[TB] FAIL overflow_state: in_ready=%0b ovf=%0b len=%0d, required 0 1 8", in_ready, overflow, vec_len);
    end
    drain_vector(0, 0);
    checks++;
    if (got_q.size() != 8) begin
      errors++;
      $display("[TB] FAIL overflow_count: got %0d beats, required 8", got_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] != i || got_last_q[i] != (i == 7)) begin
          errors++;
          $display("[TB] FAIL overflow_beat %0d: data=%0d last=%0b, required %0d %0b",
                   i, got_q[i], got_last_q[i], i, (i == 7));
        end
      end
    end
    checks++;
    if (overflow !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_sticky: ovf=%0b in_ready=%0b, required 1 1", overflow, in_ready);
    end
    // Beats 8 and 9 form the next vector.
    @(posedge clock);
    #1;
    checks++;
    if (overflow !== 1'b0 || vec_len !== 5'(1)) begin
      errors++;
      $display("[TB] FAIL overflow_clear: ovf=%0b len=%0d, required 0 1", overflow, vec_len);
    end
    in_data = DW'(9);
    in_last = 1'b1;
    @(posedge clock);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    vec_q = '{8, 9};
    drain_vector(0, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0] != 8 || got_q[1] != 9 || got_last_q[1] != 1'b1) begin
      errors++;
      $display("[TB] FAIL overflow_next: count=%0d, required beats 8 and 9 with last on 9", got_q.size());
    end
  endtask

  task automatic test_reset_mid();
    vec_q.delete();
    for (int i = 0; i < 5; i++) vec_q.push_back(int'($urandom));
    load_vector(1'b1);
    drain_vector(2, 0);
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || vec_len !== '0 || in_ready !== 1'b1 || out_last !== 1'b0 || ram_enable_b !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid: valid=%0b len=%0d in_ready=%0b last=%0b enb=%0b, required 0 0 1 0 0",
               out_valid, vec_len, in_ready, out_last, ram_enable_b);
    end
    @(negedge clock);
    reset_n = 1'b1;
    vec_q.delete();
    for (int i = 0; i < 3; i++) vec_q.push_back(int'($urandom));
    load_vector(1'b1);
    drain_vector(0, 0);
    checks++;
    if (got_q.size() != 3) begin
      errors++;
      $display("[TB] FAIL reset_mid_count: got %0d beats, required 3", got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (got_q[i] != vec_q[i] || got_last_q[i] != (i == 2)) begin
          errors++;
          $display("[TB] FAIL reset_mid_beat %0d: data=%0d last=%0b, required %0d %0b",
                   i, got_q[i], got_last_q[i], vec_q[i], (i == 2));
        end
      end
    end
  endtask

  task automatic test_max_track();
    vec_q = '{1, 4};
    load_vector(1'b1);
    @(negedge clock);
    #1;
    checks++;
    if (vec_max !== DW'(model_max()) || vec_len !== 5'(2)) begin
      errors++;
      $display("[TB] FAIL max_track: max=%0d len=%0d, required %0d 2", $signed(vec_max), vec_len, model_max());
    end
    drain_vector(0, 0);
    checks++;
    if (got_q.size() != 2 || got_q[0] != 1 || got_q[1] != 4 || got_last_q[1] != 1'b1) begin
      errors++;
      $display("[TB] FAIL max_track_replay: count=%0d, required beats 1 and 4 with last on 4", got_q.size());
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 20; t++) begin
      int n;
      n = int'($urandom_range(1, TW));
      vec_q.delete();
      for (int i = 0; i < n; i++) vec_q.push_back(int'($urandom));
      load_vector(1'b1);
      @(negedge clock);
      #1;
      checks++;
      if (vec_len !== 5'(n) || vec_max !== DW'(model_max())) begin
        errors++;
        $display("[TB] FAIL random_stats %0d: len=%0d max=%0d, required %0d %0d",
                 t, vec_len, $signed(vec_max), n, model_max());
      end
      drain_vector(0, 2);
      checks++;
      if (got_q.size() != n) begin
        errors++;
        $display("[TB] FAIL random_count %0d: got %0d beats, required %0d", t, got_q.size(), n);
      end else begin
        for (int i = 0; i < n; i++) begin
          checks++;
          if (got_q[i] != vec_q[i] || got_last_q[i] != (i == n - 1)) begin
            errors++;
            $display("[TB] FAIL random_beat %0d.%0d: data=%0d last=%0b, required %0d %0b",
                     t, i, got_q[i], got_last_q[i], vec_q[i], (i == n - 1));
          end
        end
      end
    end
  endtask

  // Run every scenario in order, then print the summary.
  initial begin
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_single();
    test_overflow();
    test_reset_mid();
    test_max_track();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit, as a backstop behind the per-wait budgets.
  initial begin
    #2_000_000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
